// File: rtl/etc_block_sequencer.sv
// ETC2 block sequencer: requests the 16 decoded pixels of a block one at a time
// in column-major order, buffers them, then streams them out in raster order.
//
// state | meaning
// IDLE  | ready for a new compressed block
// REQ   | one-cycle pixel request to the decoder
// WAIT  | waiting for the decoder response or the pixel timeout
// DRAIN | streaming the 16 buffered pixels downstream
module etc_block_sequencer #(
  parameter logic [7:0] PIX_TIMEOUT = 8'd255
) (
  input  logic        sclk,
  input  logic        rsrt,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [63:0] blk_data,
  input  logic        blk_flags,
  output logic [63:0] dec_block,
  output logic        dec_flags,
  output logic        dec_rtr,
  output logic [3:0]  dec_pixIdx,
  input  logic        dec_rts,
  input  logic [7:0]  dec_r,
  input  logic [7:0]  dec_g,
  input  logic [7:0]  dec_b,
  input  logic [7:0]  dec_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rgba,
  output logic [1:0]  out_x,
  output logic [1:0]  out_y,
  output logic        out_last,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  k;
  logic [7:0]  wcnt;
  logic [31:0] pix_buf [16];
  logic        pix_done;
  logic        timed_out;

  // Combinational handshakes are gated by rsrt so they drop during the reset cycle itself.
  assign blk_ready  = (state == S_IDLE) && !rsrt;
  assign dec_rtr    = (state == S_REQ) && !rsrt;
  assign out_valid  = (state == S_DRAIN) && !rsrt;
  assign out_last   = out_valid && (k == 4'd15);
  assign dec_pixIdx = idx;

  assign timed_out = !dec_rts && (wcnt == PIX_TIMEOUT);
  assign pix_done  = (state == S_WAIT) && !rsrt && (dec_rts || timed_out);

  assign out_x    = k[1:0];
  assign out_y    = k[3:2];
  assign out_rgba = pix_buf[{k[1:0], k[3:2]}];

  always_ff @(posedge sclk) begin
    if (rsrt) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      k         <= 4'd0;
      wcnt      <= 8'd0;
      dec_block <= 64'd0;
      dec_flags <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid) begin
            dec_block <= blk_data;
            dec_flags <= blk_flags;
            err       <= 1'b0;
            idx       <= 4'd0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          wcnt  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (pix_done) begin
            if (timed_out) err <= 1'b1;
            if (idx == 4'd15) begin
              k     <= 4'd0;
              state <= S_DRAIN;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_REQ;
            end
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: begin
          if (out_ready) begin
            k <= k + 4'd1;
            if (k == 4'd15) state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Pixel storage is fully written before it is ever read, so it carries no reset.
  always_ff @(posedge sclk) begin
    if (pix_done) pix_buf[idx] <= dec_rts ? {dec_a, dec_b, dec_g, dec_r} : 32'h0;
  end

endmodule
